// File: rtl/mux2_pkg.sv
// Shared constants and the bitwise vote used by the tri-style 2:1 select.
// Latency: n/a (package only).
// Backpressure: n/a.
package mux2_pkg;

    localparam int WIDTH_DEFAULT = 1;
    localparam int WIDTH_MAX     = 64;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/mux2_gate_bit.sv
// One-bit 2:1 mux built only from not/and/or gate primitives.
// Latency: combinational.
// Backpressure: none.
module mux2_gate_bit (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    wire sel_n;
    wire a_term;
    wire b_term;
    wire y_int;

    not u_not   (sel_n, sel);
    and u_and_a (a_term, a, sel_n);
    and u_and_b (b_term, b, sel);
    or  u_or    (y_int, a_term, b_term);

    assign y = y_int;

endmodule

// File: rtl/mux2_tri_style.sv
// Registered 2:1 select computed as dataflow, behavioral and gate netlist, voted 2-of-3.
// Latency: 1 cycle; MUX2_FAULT_INJECT_EN adds fault_inject to invert the structural path.
// Backpressure: none; outputs hold while in_valid=0, out_valid/mismatch drop to 0.
module mux2_tri_style
    import mux2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MUX2_FAULT_INJECT_EN
    input  logic             fault_inject,
`endif
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] y_dataflow,
    output logic [WIDTH-1:0] y_behavioral,
    output logic [WIDTH-1:0] y_structural,
    output logic [WIDTH-1:0] y,
    output logic             mismatch,
    output logic             mismatch_sticky
);

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_h;
    logic [WIDTH-1:0] y_s_raw;
    logic [WIDTH-1:0] y_s;
    logic [WIDTH-1:0] y_maj;
    logic             diff;
    logic             mismatch_nxt;

    assign y_d = sel ? b : a;

    always_comb begin
        y_h = a;
        if (sel) begin
            y_h = b;
        end else begin
            y_h = a;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2_gate_bit u_bit (
            .a   (a[i]),
            .b   (b[i]),
            .sel (sel),
            .y   (y_s_raw[i])
        );
        assign y_maj[i] = maj3(y_d[i], y_h[i], y_s[i]);
    end

`ifdef MUX2_FAULT_INJECT_EN
    assign y_s = fault_inject ? ~y_s_raw : y_s_raw;
`else
    assign y_s = y_s_raw;
`endif

    assign diff         = |((y_d ^ y_h) | (y_d ^ y_s));
    assign mismatch_nxt = in_valid & diff;

    // Sticky uses the pre-register flag so it rises together with mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            y_dataflow      <= '0;
            y_behavioral    <= '0;
            y_structural    <= '0;
            y               <= '0;
            mismatch        <= 1'b0;
            mismatch_sticky <= 1'b0;
        end else begin
            out_valid       <= in_valid;
            mismatch        <= mismatch_nxt;
            mismatch_sticky <= mismatch_sticky | mismatch_nxt;
            if (in_valid) begin
                y_dataflow   <= y_d;
                y_behavioral <= y_h;
                y_structural <= y_s;
                y            <= y_maj;
            end
        end
    end

endmodule

// File: tb/tb_mux2_tri_style.sv
// Directed bench for mux2_tri_style at WIDTH=1 and WIDTH=8; fault checks under MUX2_FAULT_INJECT_EN.
module tb_mux2_tri_style;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       sel;
    logic       a1, b1;
    logic [7:0] a8, b8;
`ifdef MUX2_FAULT_INJECT_EN
    logic       fault;
`endif

    logic       ov1, yd1, yh1, ys1, y1, mm1, st1;
    logic       ov8, mm8, st8;
    logic [7:0] yd8, yh8, ys8, y8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2_tri_style #(.WIDTH(1)) u1 (
        .clk             (clk),
        .rst_n           (rst_n),
`ifdef MUX2_FAULT_INJECT_EN
        .fault_inject    (1'b0),
`endif
        .in_valid        (in_valid),
        .a               (a1),
        .b               (b1),
        .sel             (sel),
        .out_valid       (ov1),
        .y_dataflow      (yd1),
        .y_behavioral    (yh1),
        .y_structural    (ys1),
        .y               (y1),
        .mismatch        (mm1),
        .mismatch_sticky (st1)
    );

    mux2_tri_style #(.WIDTH(8)) u8 (
        .clk             (clk),
        .rst_n           (rst_n),
`ifdef MUX2_FAULT_INJECT_EN
        .fault_inject    (fault),
`endif
        .in_valid        (in_valid),
        .a               (a8),
        .b               (b8),
        .sel             (sel),
        .out_valid       (ov8),
        .y_dataflow      (yd8),
        .y_behavioral    (yh8),
        .y_structural    (ys8),
        .y               (y8),
        .mismatch        (mm8),
        .mismatch_sticky (st8)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected value is applied to all three styles, the vote, and the flags.
    task automatic chk_w1(input string tag, input logic exp, input logic exp_ov, input logic exp_st);
        chk1({tag, "_yd1"}, yd1, exp);
        chk1({tag, "_yh1"}, yh1, exp);
        chk1({tag, "_ys1"}, ys1, exp);
        chk1({tag, "_y1"},  y1,  exp);
        chk1({tag, "_ov1"}, ov1, exp_ov);
        chk1({tag, "_mm1"}, mm1, 1'b0);
        chk1({tag, "_st1"}, st1, exp_st);
    endtask

    task automatic chk_w8(input string tag, input logic [7:0] exp, input logic exp_ov, input logic exp_st);
        chk8({tag, "_yd8"}, yd8, exp);
        chk8({tag, "_yh8"}, yh8, exp);
        chk8({tag, "_ys8"}, ys8, exp);
        chk8({tag, "_y8"},  y8,  exp);
        chk1({tag, "_ov8"}, ov8, exp_ov);
        chk1({tag, "_mm8"}, mm8, 1'b0);
        chk1({tag, "_st8"}, st8, exp_st);
    endtask

    initial begin
`ifdef MUX2_FAULT_INJECT_EN
        fault    = 1'b0;
`endif
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b1; sel = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF;

        // Reset held across edges with live inputs: everything stays 0.
        repeat (3) @(negedge clk);
        chk_w1("rst", 1'b0, 1'b0, 1'b0);
        chk_w8("rst", 8'h00, 1'b0, 1'b0);

        rst_n = 1'b1;
        @(negedge clk);
        chk_w1("rel", 1'b1, 1'b1, 1'b0);
        chk_w8("rel", 8'hFF, 1'b1, 1'b0);

        // Truth table; wide instance rides along with a8=5A, b8=C3.
        a8 = 8'h5A; b8 = 8'hC3;
        a1 = 1'b0; b1 = 1'b0; sel = 1'b0;
        @(negedge clk);
        chk_w1("tt000", 1'b0, 1'b1, 1'b0);
        chk_w8("tt000", 8'h5A, 1'b1, 1'b0);
        a1 = 1'b0; b1 = 1'b1; sel = 1'b0;
        @(negedge clk);
        chk_w1("tt010", 1'b0, 1'b1, 1'b0);
        a1 = 1'b1; b1 = 1'b0; sel = 1'b1;
        @(negedge clk);
        chk_w1("tt101", 1'b0, 1'b1, 1'b0);
        chk_w8("tt101", 8'hC3, 1'b1, 1'b0);
        a1 = 1'b1; b1 = 1'b1; sel = 1'b1;
        @(negedge clk);
        chk_w1("tt111", 1'b1, 1'b1, 1'b0);

        // Wide select.
        a8 = 8'hA5; b8 = 8'h3C; sel = 1'b0;
        @(negedge clk);
        chk_w8("wide_s0", 8'hA5, 1'b1, 1'b0);
        sel = 1'b1;
        @(negedge clk);
        chk_w8("wide_s1", 8'h3C, 1'b1, 1'b0);

        // Hold: in_valid low, inputs wander, registers keep 3C / 1.
        in_valid = 1'b0;
        a8 = 8'h00; b8 = 8'h11; sel = 1'b0; a1 = 1'b0; b1 = 1'b0;
        @(negedge clk);
        chk_w8("hold0", 8'h3C, 1'b0, 1'b0);
        chk_w1("hold0", 1'b1, 1'b0, 1'b0);
        a8 = 8'h77; b8 = 8'h88; sel = 1'b1;
        @(negedge clk);
        chk_w8("hold1", 8'h3C, 1'b0, 1'b0);

        // Async reset between edges: outputs clear with no clock edge.
        in_valid = 1'b1;
        a8 = 8'h96; sel = 1'b0;
        @(negedge clk);
        chk_w8("pre_arst", 8'h96, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_w8("arst", 8'h00, 1'b0, 1'b0);
        chk_w1("arst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h69; sel = 1'b0;
        @(negedge clk);
        chk_w8("post_arst", 8'h69, 1'b1, 1'b0);

`ifdef MUX2_FAULT_INJECT_EN
        fault = 1'b1;
        a8 = 8'h0F; b8 = 8'h00; sel = 1'b0;
        @(negedge clk);
        chk8("fi_ys", ys8, 8'hF0);
        chk8("fi_y",  y8,  8'h0F);
        chk8("fi_yd", yd8, 8'h0F);
        chk1("fi_mm", mm8, 1'b1);
        chk1("fi_st", st8, 1'b1);
        chk1("fi_st1_clean", st1, 1'b0);
        fault = 1'b0;
        @(negedge clk);
        chk8("fi_off_ys", ys8, 8'h0F);
        chk1("fi_off_mm", mm8, 1'b0);
        chk1("fi_off_st", st8, 1'b1);
        in_valid = 1'b0;
        fault = 1'b1;
        @(negedge clk);
        chk1("fi_inval_mm", mm8, 1'b0);
        chk8("fi_inval_ys", ys8, 8'h0F);
        fault = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("fi_rst_st", st8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk_w8("fi_after", 8'h0F, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
